// File: rtl/oled_text_pkg.sv
// Shared types and constants for the OLED text renderer: panel geometry, FSM
// states and the 8x8 glyph bitmaps (font8x8_basic layout, bit 0 = leftmost pixel).
package oled_text_pkg;

    typedef logic [15:0] rgb565_t;

    localparam int PANEL_W = 96;
    localparam int PANEL_H = 64;
    localparam int CHAR_W  = 8;
    localparam int CHAR_H  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WIN,
        ST_PIX,
        ST_DONE
    } state_t;

    // Row 0 sits in the least significant byte, row 7 in the most significant.
    localparam logic [63:0] GLYPH_BLANK = 64'h0000_0000_0000_0000;
    localparam logic [63:0] GLYPH_SPACE = 64'h0000_0000_0000_0000;
    localparam logic [63:0] GLYPH_E     = 64'h007F_4616_1E16_467F;
    localparam logic [63:0] GLYPH_G     = 64'h007C_6673_0303_663C;
    localparam logic [63:0] GLYPH_O     = 64'h001C_3663_6363_361C;
    localparam logic [63:0] GLYPH_R     = 64'h0067_6636_3E66_663F;
    localparam logic [63:0] GLYPH_S     = 64'h001E_3338_0E07_331E;

endpackage

// File: rtl/oled_glyph_rom.sv
// Combinational glyph lookup: (character code, font row) -> 8-bit row bitmap.
// Codes without a glyph render blank.
module oled_glyph_rom
    import oled_text_pkg::*;
(
    input  logic [7:0] code,
    input  logic [2:0] row,
    output logic [7:0] bits
);

    logic [63:0] glyph;

    always_comb begin
        // NOTE: default assignment first so every path drives glyph; no latch.
        glyph = GLYPH_BLANK;
        case (code)
            8'h20:   glyph = GLYPH_SPACE;
            8'h45:   glyph = GLYPH_E;
            8'h47:   glyph = GLYPH_G;
            8'h4F:   glyph = GLYPH_O;
            8'h52:   glyph = GLYPH_R;
            8'h53:   glyph = GLYPH_S;
            default: glyph = GLYPH_BLANK;
        endcase
    end

    assign bits = glyph[{row, 3'b000} +: 8];

endmodule

// File: rtl/oled_text_renderer.sv
// Renders a latched NUM_CHARS string as an 8x8-font RGB565 pixel stream:
// one drawing-window command, then every pixel in raster order over valid/ready.
module oled_text_renderer
    import oled_text_pkg::*;
#(
    parameter int      NUM_CHARS = 3,
    parameter rgb565_t FG_COLOR  = 16'hFFFF,
    parameter rgb565_t BG_COLOR  = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic [8*NUM_CHARS-1:0] i_ascii,
    input  logic [2:0]             i_text_row,
    input  logic [3:0]             i_text_col,
    output logic                   o_busy,
    output logic                   o_win_valid,
    input  logic                   i_win_ready,
    output logic [6:0]             o_win_col_start,
    output logic [6:0]             o_win_col_end,
    output logic [5:0]             o_win_row_start,
    output logic [5:0]             o_win_row_end,
    output logic                   o_pix_valid,
    output logic [15:0]            o_pix_data,
    input  logic                   i_pix_ready,
    output logic                   o_done
);

    localparam int             CW      = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam int             COL_W   = $clog2(PANEL_W);
    localparam int             ROW_W   = $clog2(PANEL_H);
    localparam logic [3:0]     MAX_COL = 4'(PANEL_W / CHAR_W - NUM_CHARS);
    localparam logic [CW-1:0]  LAST_C  = CW'(NUM_CHARS - 1);

    state_t                       state;
    logic [NUM_CHARS-1:0][7:0]    text_q;
    logic [2:0]                   cnt_r, nxt_r;
    logic [CW-1:0]                cnt_c, nxt_c;
    logic [2:0]                   cnt_b, nxt_b;
    logic [3:0]                   col_clamped;
    logic [COL_W-1:0]             win_col_start, win_col_end;
    logic [ROW_W-1:0]             win_row_start, win_row_end;
    logic [7:0]                   char_code;
    logic [7:0]                   glyph_bits;
    rgb565_t                      nxt_pix;
    logic                         last_pix;

    assign col_clamped   = (i_text_col > MAX_COL) ? MAX_COL : i_text_col;
    assign win_col_start = COL_W'(col_clamped * CHAR_W);
    assign win_col_end   = win_col_start + COL_W'(CHAR_W * NUM_CHARS - 1);
    assign win_row_start = ROW_W'(i_text_row * CHAR_H);
    assign win_row_end   = win_row_start + ROW_W'(CHAR_H - 1);

    // Position of the pixel to present after the next handshake; (0,0,0) outside PIX
    // so the window handshake preloads the first pixel.
    always_comb begin
        nxt_r = '0;
        nxt_c = '0;
        nxt_b = '0;
        if (state == ST_PIX) begin
            nxt_r = cnt_r;
            nxt_c = cnt_c;
            nxt_b = cnt_b + 3'd1;
            if (cnt_b == 3'd7) begin
                if (cnt_c == LAST_C) begin
                    nxt_c = '0;
                    nxt_r = cnt_r + 3'd1;
                end else begin
                    nxt_c = cnt_c + CW'(1);
                end
            end
        end
    end

    assign last_pix  = (cnt_r == 3'd7) && (cnt_c == LAST_C) && (cnt_b == 3'd7);
    assign char_code = text_q[LAST_C - nxt_c];
    assign nxt_pix   = glyph_bits[nxt_b] ? FG_COLOR : BG_COLOR;

    oled_glyph_rom u_glyph_rom (
        .code (char_code),
        .row  (nxt_r),
        .bits (glyph_bits)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            // NOTE: the string latch is small flops, so it is reset with everything else.
            text_q          <= '0;
            cnt_r           <= '0;
            cnt_c           <= '0;
            cnt_b           <= '0;
            o_busy          <= 1'b0;
            o_win_valid     <= 1'b0;
            o_win_col_start <= '0;
            o_win_col_end   <= '0;
            o_win_row_start <= '0;
            o_win_row_end   <= '0;
            o_pix_valid     <= 1'b0;
            o_pix_data      <= '0;
            o_done          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        text_q          <= i_ascii;
                        o_win_col_start <= win_col_start;
                        o_win_col_end   <= win_col_end;
                        o_win_row_start <= win_row_start;
                        o_win_row_end   <= win_row_end;
                        o_win_valid     <= 1'b1;
                        o_busy          <= 1'b1;
                        state           <= ST_WIN;
                    end
                end
                ST_WIN: begin
                    if (i_win_ready) begin
                        o_win_valid <= 1'b0;
                        o_pix_valid <= 1'b1;
                        o_pix_data  <= nxt_pix;
                        cnt_r       <= nxt_r;
                        cnt_c       <= nxt_c;
                        cnt_b       <= nxt_b;
                        state       <= ST_PIX;
                    end
                end
                ST_PIX: begin
                    if (o_pix_valid && i_pix_ready) begin
                        if (last_pix) begin
                            o_pix_valid <= 1'b0;
                            o_pix_data  <= '0;
                            o_done      <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            o_pix_data <= nxt_pix;
                            cnt_r      <= nxt_r;
                            cnt_c      <= nxt_c;
                            cnt_b      <= nxt_b;
                        end
                    end
                end
                ST_DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    cnt_r  <= '0;
                    cnt_c  <= '0;
                    cnt_b  <= '0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oled_text_renderer.sv
// Self-checking bench for oled_text_renderer: a per-cycle monitor compares the
// DUT stream against a font/raster model built from the glyph tables below.
module tb_oled_text_renderer;

    localparam int          N  = 3;
    localparam logic [15:0] FG = 16'hFFFF;
    localparam logic [15:0] BG = 16'h0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [23:0]   i_ascii = '0;
    logic [2:0]    i_text_row = '0;
    logic [3:0]    i_text_col = '0;
    logic          i_win_ready = 1'b1;
    logic          i_pix_ready = 1'b1;
    logic          o_busy, o_win_valid, o_pix_valid, o_done;
    logic [6:0]    o_win_col_start, o_win_col_end;
    logic [5:0]    o_win_row_start, o_win_row_end;
    logic [15:0]   o_pix_data;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int cyc0 = 0;

    // Model state (written by the stimulus process only)
    logic [15:0] exp_pix[$];
    int exp_cs, exp_ce, exp_rs, exp_re;

    // Monitor state (written by the monitor only)
    int          pix_idx = 0;
    int          done_total = 0;
    int          done_cyc = 0;
    bit          prev_pix_stall = 0;
    bit          prev_win_stall = 0;
    logic [15:0] prev_data = '0;

    oled_text_renderer #(
        .NUM_CHARS (N),
        .FG_COLOR  (FG),
        .BG_COLOR  (BG)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_start         (i_start),
        .i_ascii         (i_ascii),
        .i_text_row      (i_text_row),
        .i_text_col      (i_text_col),
        .o_busy          (o_busy),
        .o_win_valid     (o_win_valid),
        .i_win_ready     (i_win_ready),
        .o_win_col_start (o_win_col_start),
        .o_win_col_end   (o_win_col_end),
        .o_win_row_start (o_win_row_start),
        .o_win_row_end   (o_win_row_end),
        .o_pix_valid     (o_pix_valid),
        .o_pix_data      (o_pix_data),
        .i_pix_ready     (i_pix_ready),
        .o_done          (o_done)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] font_row(input logic [7:0] ch, input int r);
        logic [7:0] g [8];
        case (ch)
            8'h45:   g = '{8'h7F, 8'h46, 8'h16, 8'h1E, 8'h16, 8'h46, 8'h7F, 8'h00};
            8'h47:   g = '{8'h3C, 8'h66, 8'h03, 8'h03, 8'h73, 8'h66, 8'h7C, 8'h00};
            8'h4F:   g = '{8'h1C, 8'h36, 8'h63, 8'h63, 8'h63, 8'h36, 8'h1C, 8'h00};
            8'h52:   g = '{8'h3F, 8'h66, 8'h66, 8'h3E, 8'h36, 8'h66, 8'h67, 8'h00};
            8'h53:   g = '{8'h1E, 8'h33, 8'h07, 8'h0E, 8'h38, 8'h33, 8'h1E, 8'h00};
            default: g = '{default: 8'h00};
        endcase
        return g[r];
    endfunction

    task automatic build_model(input logic [23:0] s, input int row, input int col);
        int         cc;
        logic [7:0] ch, g;
        cc = (col > 12 - N) ? 12 - N : col;
        exp_cs = 8 * cc;
        exp_ce = exp_cs + 8 * N - 1;
        exp_rs = 8 * row;
        exp_re = exp_rs + 7;
        exp_pix.delete();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < N; c++) begin
                ch = s[8 * (N - 1 - c) +: 8];
                g  = font_row(ch, r);
                for (int b = 0; b < 8; b++)
                    exp_pix.push_back(g[b] ? FG : BG);
            end
    endtask

    // Per-cycle monitor; a handshake is predicted from the ready level seen here,
    // which the stimulus holds until after the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pix_stall = 0;
            prev_win_stall = 0;
        end else begin
            check("valid_exclusive", {31'd0, o_win_valid & o_pix_valid}, 0);
            if (prev_win_stall) check("win_hold_valid", {31'd0, o_win_valid}, 1);
            if (o_win_valid) begin
                check("win_fields", {6'd0, o_win_col_start, o_win_col_end, o_win_row_start, o_win_row_end},
                      {6'd0, 7'(exp_cs), 7'(exp_ce), 6'(exp_rs), 6'(exp_re)});
                if (i_win_ready) pix_idx = 0;
            end
            if (prev_pix_stall) begin
                check("pix_hold_valid", {31'd0, o_pix_valid}, 1);
                check("pix_hold_data", {16'd0, o_pix_data}, {16'd0, prev_data});
            end
            if (o_pix_valid) begin
                if (pix_idx < exp_pix.size())
                    check($sformatf("pix_data[%0d]", pix_idx), {16'd0, o_pix_data}, {16'd0, exp_pix[pix_idx]});
                else
                    check("pix_overrun", pix_idx, exp_pix.size() - 1);
                if (i_pix_ready) pix_idx++;
            end
            prev_pix_stall = o_pix_valid && !i_pix_ready;
            prev_data      = o_pix_data;
            prev_win_stall = o_win_valid && !i_win_ready;
            if (o_done) begin
                check("done_after_last", pix_idx, exp_pix.size());
                check("busy_at_done", {31'd0, o_busy}, 1);
                done_total++;
                done_cyc = cyc;
            end
        end
    end

    // Start is sampled at the next rising edge (cycle 0); returns inside cycle 1.
    task automatic start_run(input logic [23:0] s, input int row, input int col);
        @(posedge clk);
        #1;
        i_start    = 1'b1;
        i_ascii    = s;
        i_text_row = 3'(row);
        i_text_col = 4'(col);
        @(posedge clk);
        #1;
        cyc0    = cyc - 1;
        i_start = 1'b0;
        check("cycle1_win_valid", {31'd0, o_win_valid}, 1);
        check("cycle1_busy", {31'd0, o_busy}, 1);
    endtask

    task automatic wait_done(input int budget, input bit rnd, input int win_delay,
                             input int inject_at, input logic [23:0] inject_s);
        int base;
        bit ok;
        base = done_total;
        ok   = 0;
        for (int n = 0; n < budget; n++) begin
            i_win_ready = (n >= win_delay);
            i_pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (n == inject_at) begin
                i_start = 1'b1;
                i_ascii = inject_s;
            end else begin
                i_start = 1'b0;
            end
            if (n < win_delay) check("no_pix_during_win", {31'd0, o_pix_valid}, 0);
            @(posedge clk);
            #1;
            if (done_total > base) begin
                ok = 1;
                break;
            end
        end
        check("done_reached", {31'd0, ok}, 1);
        i_start     = 1'b0;
        i_win_ready = 1'b1;
        i_pix_ready = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl_data"}, {12'd0, o_busy, o_win_valid, o_pix_valid, o_done, o_pix_data}, 0);
        check({tag, "_win"}, {6'd0, o_win_col_start, o_win_col_end, o_win_row_start, o_win_row_end}, 0);
    endtask

    initial begin
        logic [15:0] lit_g0 [8];
        logic [23:0] s;
        logic [7:0]  pool [7];
        int          base, fg_cnt;
        bit          reached;

        lit_g0 = '{BG, BG, FG, FG, FG, FG, BG, BG};
        pool   = '{8'h20, 8'h45, 8'h47, 8'h4F, 8'h52, 8'h53, 8'h5A};

        // Reset state
        #23;
        check_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("post_reset");

        // 1: "GO " at (0,0), readies high: exact timing
        build_model(24'h474F20, 0, 0);
        for (int i = 0; i < 8; i++) check("model_g_row0", {16'd0, exp_pix[i]}, {16'd0, lit_g0[i]});
        check("model_len", exp_pix.size(), 192);
        base = done_total;
        start_run(24'h474F20, 0, 0);
        check("go_win_literal", {6'd0, o_win_col_start, o_win_col_end, o_win_row_start, o_win_row_end},
              {6'd0, 7'd0, 7'd23, 6'd0, 6'd7});
        wait_done(400, 0, 0, -1, '0);
        check("go_done_cycle", done_cyc - cyc0, 194);
        check("go_idle_busy", {31'd0, o_busy}, 0);
        check("go_done_pulse", {31'd0, o_done}, 0);
        check("go_one_done", done_total - base, 1);

        // 2: same string, random pixel back-pressure
        build_model(24'h474F20, 0, 0);
        start_run(24'h474F20, 0, 0);
        wait_done(2000, 1, 0, -1, '0);

        // 3: "ERS" at row 7, col 11 -> clamped to col 9; window stalled 5 cycles
        build_model(24'h455253, 7, 11);
        check("model_e_row0_first", {16'd0, exp_pix[0]}, {16'd0, FG});
        check("model_e_row0_last", {16'd0, exp_pix[7]}, {16'd0, BG});
        start_run(24'h455253, 7, 11);
        check("ers_win_literal", {6'd0, o_win_col_start, o_win_col_end, o_win_row_start, o_win_row_end},
              {6'd0, 7'd72, 7'd95, 6'd56, 6'd63});
        wait_done(400, 0, 5, -1, '0);

        // 4: unknown codes render blank
        build_model(24'h414243, 3, 5);
        fg_cnt = 0;
        foreach (exp_pix[i]) if (exp_pix[i] != BG) fg_cnt++;
        check("model_blank", fg_cnt, 0);
        start_run(24'h414243, 3, 5);
        wait_done(2000, 1, 2, -1, '0);

        // 5: reset after the 50th pixel handshake, then a full fresh run
        build_model(24'h474F20, 2, 4);
        start_run(24'h474F20, 2, 4);
        reached = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (pix_idx >= 50) begin
                reached = 1;
                break;
            end
        end
        check("reached_50", {31'd0, reached}, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        build_model(24'h534547, 4, 10);
        start_run(24'h534547, 4, 10);
        wait_done(400, 0, 0, -1, '0);

        // 6: start mid-PIX ignored, exactly one done
        build_model(24'h474F20, 1, 2);
        base = done_total;
        start_run(24'h474F20, 1, 2);
        wait_done(400, 0, 0, 60, 24'h455253);
        repeat (10) @(posedge clk);
        #1;
        check("ignored_start_one_done", done_total - base, 1);
        check("ignored_start_no_win", {31'd0, o_win_valid}, 0);

        // Randomized strings, positions and back-pressure
        for (int k = 0; k < 5; k++) begin
            int row, col, wd;
            s   = {pool[$urandom_range(0, 6)], pool[$urandom_range(0, 6)], pool[$urandom_range(0, 6)]};
            row = $urandom_range(0, 7);
            col = $urandom_range(0, 15);
            wd  = $urandom_range(0, 3);
            build_model(s, row, col);
            start_run(s, row, col);
            wait_done(2000, 1, wd, -1, '0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/oled_text_renderer.md
# oled_text_renderer

Streams a short ASCII string to the OLED RGB panel (96×64, RGB565) as an 8×8-font pixel stream. Sits directly downstream of the shared font-map package. On a start pulse it latches the string and a character-cell position, then emits a drawing-window command. It then emits every pixel of the string in raster order over valid/ready handshakes, consumed by the panel command/SPI writer stage.

## Interface
Parameters:
- NUM_CHARS, 3: characters per string.
- FG_COLOR, 16'hFFFF: RGB565 colour for set font bits.
- BG_COLOR, 16'h0000: RGB565 colour for clear font bits.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle request; honoured only when idle.
- i_ascii  in  8*NUM_CHARS  string; leftmost char in the MSB byte ('h474F20 = "GO ").
- i_text_row  in  3  character row 0..7 (pixel row = 8*i_text_row).
- i_text_col  in  4  character column 0..11.
- o_busy  out  1  high from the cycle after an accepted start through the o_done cycle.
- o_win_valid  out  1  window command valid.
- i_win_ready  in  1  window command accepted when high with o_win_valid.
- o_win_col_start, o_win_col_end  out  7  pixel columns, inclusive.
- o_win_row_start, o_win_row_end  out  6  pixel rows, inclusive.
- o_pix_valid  out  1  pixel valid.
- o_pix_data  out  16  RGB565 pixel.
- i_pix_ready  in  1  pixel accepted when high with o_pix_valid.
- o_done  out  1  one-cycle pulse after the final pixel is accepted.

## Operation
- States: IDLE → WIN → PIX → DONE → IDLE.
- IDLE, i_start=1: latch i_ascii and position, and go to WIN. i_start in any other state is ignored.
- Column clamp: if i_text_col > 12−NUM_CHARS, use 12−NUM_CHARS.
- WIN: o_win_valid=1 with:
  - col_start = 8*col
  - col_end = col_start + 8*NUM_CHARS − 1
  - row_start = 8*row
  - row_end = row_start + 7
- WIN holds until i_win_ready, then goes to PIX.
- PIX: nested counters r (font row 0..7, outermost), c (char 0..NUM_CHARS−1, leftmost first), b (bit 0..7, innermost). There are 64*NUM_CHARS pixels.
- Glyph byte = rom(char c, row r). Bit b=0 is the leftmost pixel. Pixel = bit ? FG_COLOR : BG_COLOR.
- Counters advance only on o_pix_valid && i_pix_ready.
- While valid && !ready, o_pix_data must remain stable.
- Last handshake (r=7, c=NUM_CHARS−1, b=7) → DONE. DONE asserts o_done for one cycle, then goes to IDLE.
- Supported glyphs: 'h20 space, 'h45 E, 'h47 G, 'h4F O, 'h52 R, 'h53 S. Any other code renders blank (all BG_COLOR).
- Reset (any state, asynchronous): state=IDLE, all counters 0, and all outputs 0 (o_busy, o_win_valid, window fields, o_pix_valid, o_pix_data, o_done). Any in-flight transfer is abandoned.

## Timing
- Start accepted at cycle 0 → o_win_valid and o_busy high at cycle 1.
- Window handshake at cycle k → first pixel valid at cycle k+1 (registered output).
- With ready held high, throughput is one pixel per cycle. Full run for NUM_CHARS=3 with both readies high:
  - window at cycle 1
  - pixels at cycles 2..193
  - o_done at cycle 194
  - idle, accepting start, at cycle 195
- o_pix_valid and o_win_valid never deassert without a handshake, except on reset.
- o_win_valid and o_pix_valid are never high together.

## Structure
- Package oled_text_pkg holds:
  - rgb565_t typedef
  - panel constants: PANEL_W=96, PANEL_H=64, CHAR_W=8, CHAR_H=8
  - state enum
  - glyph byte constants in font8x8_basic format
- Sub-module oled_glyph_rom: combinational lookup of (8-bit code, 3-bit row) to 8-bit row bitmap; unknown codes give 8'h00.

## Test plan
1. "GO " at row 0, col 0, readies high → window cols 0..23, rows 0..7. First 8 pixels (G row 0, 'h3C) = BG,BG,FG,FG,FG,FG,BG,BG. 192 pixels total; o_done at cycle 194.
2. Same string with i_pix_ready randomly toggled → identical 192-pixel sequence; o_pix_data stable during every stall; o_done only after pixel 192.
3. "ERS" at row 7, col 11 → clamped to col 9: window cols 72..95, rows 56..63. i_win_ready held low 5 cycles → o_win_valid held with stable fields, no pixels emitted.
4. String 'h414243 (unknown codes) → 192 pixels all 16'h0000.
5. rst_n asserted after the 50th pixel handshake → all outputs 0 immediately. A new start then renders a complete 192-pixel string.
6. i_start pulsed mid-PIX with a different string → ignored; output matches the first string; exactly one o_done.
